// File: rtl/uart_avalon_master.sv
// uart_avalon_master
// Avalon-MM initiator for the rs232_0 UART slave. Turns a valid/ready TX byte
// stream into data-register writes, and polls the RX FIFO with data-register
// reads to feed a valid/ready RX byte stream. TX writes are gated by credits
// read from the control register's WSPACE field, so the slave's TX FIFO never
// overflows.
//
// Ports
//   clk_clk         in   1   system clock
//   reset_reset_n   in   1   asynchronous active-low reset
//   tx_data         in   8   byte to transmit
//   tx_valid        in   1   tx_data valid, held until tx_ready
//   tx_ready        out  1   one-cycle pulse, tx_data consumed this cycle
//   rx_data         out  8   received byte
//   rx_valid        out  1   rx_data valid, held until rx_ready
//   rx_ready        in   1   consumer accepts rx_data
//   avm_address     out  1   0 = data register, 1 = control register
//   avm_chipselect  out  1   high with every read or write
//   avm_byteenable  out  4   4'hF on register reads and control writes, 4'h1 on data writes
//   avm_read        out  1   single-cycle read strobe
//   avm_write       out  1   single-cycle write strobe
//   avm_writedata   out  32  write data
//   avm_readdata    in   32  read data, valid one cycle after avm_read
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_INIT      | write 0 to control register (disable irqs), once after reset
// S_IDLE      | arbitrate between TX and RX requests
// S_CTRL_RD   | read control register to refresh TX credits
// S_CTRL_WAIT | capture WSPACE into credit counter
// S_TX_WR     | write tx_data to data register, pulse tx_ready
// S_RX_RD     | read data register (pops slave RX FIFO)
// S_RX_WAIT   | capture byte if RVALID, else arm poll timer

module uart_avalon_master #(
  parameter int POLL_INTERVAL = 16,
  parameter int CREDIT_W      = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic [3:0]  avm_byteenable,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  localparam int TMR_W = $clog2(POLL_INTERVAL + 1);
  localparam logic [15:0] WSPACE_MAX = 16'((64'd1 << CREDIT_W) - 64'd1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CTRL_RD,
    S_CTRL_WAIT,
    S_TX_WR,
    S_RX_RD,
    S_RX_WAIT
  } state_t;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit;
  logic [TMR_W-1:0]    poll_tmr;
  logic                last_tx;
  logic                tx_req, rx_req, grant_tx;

  logic                bus_rd, bus_wr, bus_addr, bus_tx_ready;
  logic [3:0]          bus_be;
  logic [31:0]         bus_wd;

  logic [15:0]         wspace;
  logic                rd_rvalid;
  logic                readdata_unused;

  assign wspace          = avm_readdata[31:16];
  assign rd_rvalid       = avm_readdata[15];
  assign readdata_unused = ^avm_readdata[14:8];

  always_comb begin
    tx_req    = tx_valid;
    rx_req    = !rx_valid && (poll_tmr == '0);
    // On a tie, the side that did not win last time gets the bus.
    grant_tx  = tx_req && (!rx_req || !last_tx);
    state_nxt = state;
    case (state)
      S_INIT:      state_nxt = S_IDLE;
      S_IDLE: begin
        if (grant_tx)    state_nxt = (credit != '0) ? S_TX_WR : S_CTRL_RD;
        else if (rx_req) state_nxt = S_RX_RD;
      end
      S_CTRL_RD:   state_nxt = S_CTRL_WAIT;
      S_CTRL_WAIT: state_nxt = S_IDLE;
      S_TX_WR:     state_nxt = S_IDLE;
      S_RX_RD:     state_nxt = S_RX_WAIT;
      S_RX_WAIT:   state_nxt = S_IDLE;
      default:     state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    bus_rd       = 1'b0;
    bus_wr       = 1'b0;
    bus_addr     = 1'b0;
    bus_be       = 4'h0;
    bus_wd       = 32'h0;
    bus_tx_ready = 1'b0;
    case (state)
      S_INIT: begin
        bus_wr   = 1'b1;
        bus_addr = 1'b1;
        bus_be   = 4'hF;
      end
      S_CTRL_RD: begin
        bus_rd   = 1'b1;
        bus_addr = 1'b1;
        bus_be   = 4'hF;
      end
      S_TX_WR: begin
        bus_wr       = 1'b1;
        bus_be       = 4'h1;
        bus_wd       = {24'h0, tx_data};
        bus_tx_ready = 1'b1;
      end
      S_RX_RD: begin
        bus_rd = 1'b1;
        bus_be = 4'hF;
      end
      default: ;
    endcase
  end

  // The reset state is S_INIT, whose decode is a write. Qualifying the bus
  // with reset keeps every strobe low for as long as reset is held, and the
  // init write appears in the first cycle after release.
  assign avm_read       = bus_rd & reset_reset_n;
  assign avm_write      = bus_wr & reset_reset_n;
  assign avm_chipselect = (bus_rd | bus_wr) & reset_reset_n;
  assign avm_address    = bus_addr & reset_reset_n;
  assign avm_byteenable = bus_be & {4{reset_reset_n}};
  assign avm_writedata  = bus_wd & {32{reset_reset_n}};
  assign tx_ready       = bus_tx_ready & reset_reset_n;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= S_INIT;
      credit   <= '0;
      poll_tmr <= '0;
      last_tx  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE) begin
        if (grant_tx)    last_tx <= 1'b1;
        else if (rx_req) last_tx <= 1'b0;
      end

      if (state == S_CTRL_WAIT)
        credit <= (wspace > WSPACE_MAX) ? CREDIT_W'(WSPACE_MAX) : CREDIT_W'(wspace);
      else if (state == S_TX_WR)
        credit <= credit - CREDIT_W'(1);

      if (state == S_RX_WAIT)
        poll_tmr <= rd_rvalid ? '0 : TMR_W'(POLL_INTERVAL);
      else if (poll_tmr != '0)
        poll_tmr <= poll_tmr - TMR_W'(1);

      // A read is only issued while rx_valid is low, so a popped byte always
      // has somewhere to land.
      if (state == S_RX_WAIT && rd_rvalid) begin
        rx_valid <= 1'b1;
        rx_data  <= avm_readdata[7:0];
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_avalon_master.sv
module tb_uart_avalon_master;

  localparam int P = 16;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [7:0]  tx_data = 8'h0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        avm_address;
  logic        avm_chipselect;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;

  uart_avalon_master #(.POLL_INTERVAL(P), .CREDIT_W(8)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_byteenable(avm_byteenable), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model state: bytes offered / expected, slave FIFOs, credit allowance
  logic [7:0] tx_src[$];
  logic [7:0] exp_tx[$];
  logic [7:0] slave_rx[$];
  logic [7:0] exp_rx[$];
  int         ops[$];      // 1=ctrl write 2=ctrl read 3=data read 4=data write
  int         slave_w = 64;
  int         allowance = 0;
  int         ctrl_rd_n = 0, data_rd_n = 0, data_wr_n = 0, empty_rd_n = 0;
  longint     cyc = 0, last_empty = -1;
  logic [31:0] pend = 32'h0;
  bit         prev_hold = 0;
  logic [7:0] prev_data = 8'h0;
  bit         rx_hold = 0;

  // Slave + monitor: everything observed mid-cycle
  always @(negedge clk_clk) begin
    logic [7:0] b;
    cyc++;
    avm_readdata = pend;          // response to last cycle's read
    pend = $urandom;              // garbage unless a read happens now
    if (!reset_reset_n) begin
      chk({avm_read, avm_write, avm_chipselect, avm_address, tx_ready, rx_valid} == 6'b0 &&
          avm_byteenable == 4'h0 && avm_writedata == 32'h0 && rx_data == 8'h0,
          "reset_outputs", {avm_read, avm_write, avm_chipselect, tx_ready, rx_valid}, 0);
      allowance = 0;
      last_empty = -1;
      prev_hold = 0;
    end else begin
      chk(!(avm_read && avm_write), "rd_wr_exclusive", {avm_read, avm_write}, 0);
      chk(avm_chipselect == (avm_read | avm_write), "chipselect", avm_chipselect, avm_read | avm_write);
      chk(tx_ready == (avm_write && !avm_address), "tx_ready_with_data_write", tx_ready, avm_write && !avm_address);
      if (tx_ready) chk(tx_valid, "tx_ready_without_valid", tx_valid, 1);
      if (prev_hold) chk(rx_valid && rx_data == prev_data, "rx_hold", {rx_valid, rx_data}, {1'b1, prev_data});
      if (avm_read) begin
        chk(avm_byteenable == 4'hF, "read_be", avm_byteenable, 4'hF);
        if (avm_address) begin
          ctrl_rd_n++;
          ops.push_back(2);
          pend = {16'(slave_w), 16'($urandom)};
          allowance = (slave_w > 255) ? 255 : slave_w;
        end else begin
          data_rd_n++;
          ops.push_back(3);
          chk(!rx_valid, "read_while_rx_valid", rx_valid, 0);
          if (last_empty >= 0) chk(cyc - last_empty >= P + 2, "poll_gap", cyc - last_empty, P + 2);
          if (slave_rx.size() > 0) begin
            b = slave_rx.pop_front();
            pend = {16'(slave_rx.size()), 1'b1, 7'($urandom), b};
            last_empty = -1;
          end else begin
            pend = {16'h0, 1'b0, 15'($urandom)};
            last_empty = cyc;
            empty_rd_n++;
          end
        end
      end
      if (avm_write) begin
        if (avm_address) begin
          ops.push_back(1);
          chk(avm_writedata == 32'h0 && avm_byteenable == 4'hF, "ctrl_write", {avm_byteenable, avm_writedata}, 36'hF_0000_0000);
        end else begin
          ops.push_back(4);
          data_wr_n++;
          chk(avm_byteenable == 4'h1, "data_write_be", avm_byteenable, 4'h1);
          chk(allowance > 0, "credit_overrun", allowance, 1);
          chk(slave_w > 0, "tx_fifo_overflow", slave_w, 1);
          chk(exp_tx.size() != 0, "unexpected_write", exp_tx.size(), 1);
          if (exp_tx.size() != 0) begin
            b = exp_tx.pop_front();
            chk(avm_writedata == {24'h0, b}, "tx_byte", avm_writedata, {24'h0, b});
          end
          if (allowance > 0) allowance--;
          if (slave_w > 0) slave_w--;
        end
      end
      if (rx_valid && rx_ready) begin
        chk(exp_rx.size() != 0, "unexpected_rx", exp_rx.size(), 1);
        if (exp_rx.size() != 0) begin
          b = exp_rx.pop_front();
          chk(rx_data == b, "rx_byte", rx_data, b);
        end
      end
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end
  end

  // TX source: presents queued bytes, random gaps between them
  always begin
    bit cons;
    int gap;
    @(negedge clk_clk);
    cons = tx_valid && tx_ready;
    @(posedge clk_clk);
    #1;
    if (cons) begin
      void'(tx_src.pop_front());
      gap = $urandom_range(0, 2);
    end
    if (gap > 0) begin
      gap--;
      tx_valid = 1'b0;
    end else if (tx_src.size() > 0) begin
      tx_valid = 1'b1;
      tx_data  = tx_src[0];
    end else begin
      tx_valid = 1'b0;
    end
  end

  // RX sink: random back-pressure unless held off
  always begin
    @(posedge clk_clk);
    #1;
    rx_ready = rx_hold ? 1'b0 : 1'($urandom_range(0, 1));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_clk);
    #2;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_src.push_back(b);
    exp_tx.push_back(b);
  endtask

  task automatic push_rx(input logic [7:0] b);
    slave_rx.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((tx_src.size() != 0 || exp_tx.size() != 0 || slave_rx.size() != 0 ||
            exp_rx.size() != 0) && n < budget) begin
      @(posedge clk_clk);
      n++;
    end
    #2;
    chk(n < budget, {"drain_", name}, n, budget);
  endtask

  typedef struct {
    int w_set;     // new WSPACE, -1 keeps the slave's current value
    int nbytes;
    int exp_ctrl;
    int exp_wr;
  } tx_vec_t;

  initial begin
    tx_vec_t vec[4];
    int c0, w0, r0, e0, n;

    vec[0] = '{64,  3,   1, 3};    // 64 credits, 61 left
    vec[1] = '{-1,  61,  0, 61};   // spend the rest, no re-read
    vec[2] = '{300, 256, 2, 256};  // clamp to 255, re-read returns 45
    vec[3] = '{-1,  44,  0, 44};   // spend leftover 44

    // Reset release: first cycle is the init write, second is an idle bus
    cycles(3);
    reset_reset_n = 1'b1;
    @(negedge clk_clk); #1;
    chk(avm_write && avm_address && avm_chipselect && !avm_read &&
        avm_byteenable == 4'hF && avm_writedata == 32'h0,
        "init_write_cycle1", {avm_write, avm_address, avm_byteenable}, 6'b11_1111);
    @(negedge clk_clk); #1;
    chk({avm_read, avm_write, avm_chipselect, tx_ready, rx_valid} == 5'b0 && avm_byteenable == 4'h0,
        "idle_cycle2", {avm_read, avm_write, avm_chipselect}, 0);

    // Credit table
    for (int i = 0; i < 4; i++) begin
      c0 = ctrl_rd_n;
      w0 = data_wr_n;
      if (vec[i].w_set >= 0) slave_w = vec[i].w_set;
      for (int k = 0; k < vec[i].nbytes; k++)
        push_tx((i == 0) ? 8'(8'h41 + k) : 8'($urandom));
      drain(5000, "tx_vec");
      cycles(5);
      chk(ctrl_rd_n - c0 == vec[i].exp_ctrl, "vec_ctrl_reads", ctrl_rd_n - c0, vec[i].exp_ctrl);
      chk(data_wr_n - w0 == vec[i].exp_wr, "vec_data_writes", data_wr_n - w0, vec[i].exp_wr);
    end

    // WSPACE=0 stalls TX; then 2 credits allow exactly two writes
    slave_w = 0;
    c0 = ctrl_rd_n;
    w0 = data_wr_n;
    push_tx(8'hA1); push_tx(8'hA2); push_tx(8'hA3);
    cycles(30);
    chk(data_wr_n == w0, "no_write_at_zero_wspace", data_wr_n - w0, 0);
    chk(ctrl_rd_n - c0 >= 2, "ctrl_repoll", ctrl_rd_n - c0, 2);
    slave_w = 2;
    cycles(40);
    chk(data_wr_n - w0 == 2, "two_credit_writes", data_wr_n - w0, 2);
    chk(tx_src.size() == 1, "third_byte_waits", tx_src.size(), 1);
    slave_w = 5;
    drain(500, "wspace_refill");

    // Received byte held under back-pressure, no further data reads
    rx_hold = 1;
    cycles(2);
    push_rx(8'h5A);
    n = 0;
    while (!rx_valid && n < 80) begin @(negedge clk_clk); n++; end
    chk(n < 80, "rx_valid_timeout", n, 80);
    r0 = data_rd_n;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_clk); #1;
      chk(rx_valid && rx_data == 8'h5A, "rx_held", {rx_valid, rx_data}, 9'h15A);
    end
    chk(data_rd_n == r0, "no_read_while_held", data_rd_n - r0, 0);
    rx_hold = 0;
    drain(200, "rx_hold_release");

    // Idle polling rate
    e0 = empty_rd_n;
    cycles(200);
    chk(empty_rd_n - e0 >= 8, "idle_poll_count", empty_rd_n - e0, 8);

    // Random mixed traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0 && slave_rx.size() < 4) push_rx(8'($urandom));
      if ($urandom_range(0, 5) == 0) push_tx(8'($urandom));
      if ($urandom_range(0, 49) == 0) slave_w += 8;
      cycles(1);
    end
    drain(5000, "random");

    // Alternation after reset, and reset mid CTRL_WAIT
    @(posedge clk_clk); #2;
    reset_reset_n = 1'b0;
    cycles(3);
    slave_w = 3;
    push_tx(8'hC3);
    cycles(2);
    ops.delete();
    reset_reset_n = 1'b1;
    n = 0;
    while (ops.size() < 2 && n < 20) begin @(negedge clk_clk); #1; n++; end
    chk(n < 20, "ctrl_read_timeout", n, 20);
    chk(ops.size() == 2 && ops[0] == 1 && ops[1] == 2, "tx_first_after_reset", ops.size(), 2);
    @(posedge clk_clk); #2;          // now in the read-response cycle
    reset_reset_n = 1'b0;
    #1;
    chk({avm_read, avm_write, avm_chipselect, tx_ready} == 4'b0, "strobes_drop_on_reset",
        {avm_read, avm_write, avm_chipselect, tx_ready}, 0);
    cycles(2);
    ops.delete();
    reset_reset_n = 1'b1;
    repeat (10) @(negedge clk_clk);
    #1;
    if (ops.size() >= 4)
      chk(ops[0] == 1 && ops[1] == 2 && ops[2] == 3 && ops[3] == 4, "alternation_order",
          {ops[0][3:0], ops[1][3:0], ops[2][3:0], ops[3][3:0]}, 16'h1234);
    else
      chk(ops.size() >= 4, "alternation_op_count", ops.size(), 4);
    drain(500, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
